// File: rtl/line_buffer_pkg.sv
// Shared constants, types and helpers for the line buffer feeding the 3x3 convolution.
package line_buffer_pkg;
  localparam int HRES       = 240;
  localparam int VRES       = 320;
  localparam int DATA_WIDTH = 16;
  localparam int HCOUNT_W   = 8;
  localparam int VCOUNT_W   = 9;
  localparam int NUM_LINES  = 3;
  localparam int STAGES     = 2;

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef logic [1:0]            line_idx_t;

  typedef struct packed {
    pixel_t              data;
    logic [HCOUNT_W-1:0] h;
    logic [VCOUNT_W-1:0] v;
    line_idx_t           idx1;
    line_idx_t           idx2;
  } meta_t;

  // Modulo-3 add for line-store indices.
  function automatic line_idx_t idx_add(input line_idx_t i, input line_idx_t n);
    logic [2:0] s;
    s = {1'b0, i} + {1'b0, n};
    return (s >= 3'd3) ? line_idx_t'(s - 3'd3) : s[1:0];
  endfunction
endpackage

// File: rtl/line_buffer_if.sv
// Pixel-in / column-out bus of the line buffer.
interface line_buffer_if;
  import line_buffer_pkg::*;
  pixel_t                        data_in;
  logic [HCOUNT_W-1:0]           hcount_in;
  logic [VCOUNT_W-1:0]           vcount_in;
  logic                          data_valid_in;
  logic [2:0][DATA_WIDTH-1:0]    data_out;
  logic [HCOUNT_W-1:0]           hcount_out;
  logic [VCOUNT_W-1:0]           vcount_out;
  logic                          data_valid_out;

  modport master (
    output data_in, hcount_in, vcount_in, data_valid_in,
    input  data_out, hcount_out, vcount_out, data_valid_out
  );
  modport slave (
    input  data_in, hcount_in, vcount_in, data_valid_in,
    output data_out, hcount_out, vcount_out, data_valid_out
  );
endinterface

// File: rtl/line_ram.sv
// Simple dual-port line store: one write port, one read port with a 2-register read path.
module line_ram #(
  parameter int DEPTH = 240,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q1, rd_q2;

  always_ff @(posedge clk_in)
    if (we) mem[waddr] <= wdata;

  // Only the read registers reset; array contents survive reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_q1 <= '0;
      rd_q2 <= '0;
    end else begin
      if (re) rd_q1 <= mem[raddr];
      rd_q2 <= rd_q1;
    end
  end

  assign rdata = rd_q2;
endmodule

// File: rtl/line_buffer.sv
// Rotating 3-row line buffer: emits a vertical column {v-2, v-1, v} per accepted pixel, 2-cycle latency.
module line_buffer
  import line_buffer_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_in,
  line_buffer_if.slave  bus
);
  localparam int AW = $clog2(HRES);
  localparam logic [HCOUNT_W:0]   H_LIM  = (HCOUNT_W+1)'(HRES);
  localparam logic [VCOUNT_W:0]   V_LIM  = (VCOUNT_W+1)'(VRES);
  localparam logic [HCOUNT_W-1:0] LAST_H = HCOUNT_W'(HRES-1);

  logic                               accept, sync;
  line_idx_t                          wr_idx, wsel, idx1, idx2;
  logic [NUM_LINES-1:0]               we, re;
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] rdata;
  logic [STAGES-1:0]                  vld_pipe;
  meta_t                              meta_q [STAGES];

  assign accept = bus.data_valid_in &&
                  ({1'b0, bus.hcount_in} < H_LIM) &&
                  ({1'b0, bus.vcount_in} < V_LIM);
  assign sync   = (bus.hcount_in == '0) && (bus.vcount_in == '0);
  // Frame start forces the write slot to 0, overriding the rotation state.
  assign wsel   = sync ? line_idx_t'(0) : wr_idx;
  assign idx1   = idx_add(wsel, 2'd2);
  assign idx2   = idx_add(wsel, 2'd1);

  always_comb begin
    we = '0;
    re = '0;
    if (accept) begin
      we[wsel] = 1'b1;
      re[idx1] = 1'b1;
      re[idx2] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_ram
    line_ram #(.DEPTH(HRES), .WIDTH(DATA_WIDTH)) u_ram (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .we     (we[g]),
      .waddr  (bus.hcount_in[AW-1:0]),
      .wdata  (bus.data_in),
      .re     (re[g]),
      .raddr  (bus.hcount_in[AW-1:0]),
      .rdata  (rdata[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_idx   <= '0;
      vld_pipe <= '0;
      for (int i = 0; i < STAGES; i++) meta_q[i] <= '0;
    end else begin
      if (accept) wr_idx <= (bus.hcount_in == LAST_H) ? idx_add(wsel, 2'd1) : wsel;
      vld_pipe  <= {vld_pipe[STAGES-2:0], accept};
      meta_q[0] <= '{data: bus.data_in, h: bus.hcount_in, v: bus.vcount_in,
                     idx1: idx1, idx2: idx2};
      for (int i = 1; i < STAGES; i++) meta_q[i] <= meta_q[i-1];
    end
  end

  // Read slots travel with the pixel so a rotation mid-flight cannot misroute the column.
  assign bus.data_out[0]    = meta_q[STAGES-1].data;
  assign bus.data_out[1]    = rdata[meta_q[STAGES-1].idx1];
  assign bus.data_out[2]    = rdata[meta_q[STAGES-1].idx2];
  assign bus.hcount_out     = meta_q[STAGES-1].h;
  assign bus.vcount_out     = meta_q[STAGES-1].v;
  assign bus.data_valid_out = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_line_buffer.sv
// Bench for line_buffer: image-array model of rows, per-cycle compare, literal pins.
module tb_line_buffer;
  import line_buffer_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  line_buffer_if bus();
  line_buffer dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int frame_id = 0;
  bit started = 1'b0;
  bit seen_a = 1'b0, seen_b = 1'b0;

  // Model: every accepted pixel stored by (v,h); gen tags which frame a cell belongs to.
  logic [15:0] img  [VRES][HRES];
  int          kgen [VRES][HRES];
  int          gen = 1;

  typedef struct {
    bit          zero;
    bit          vld;
    bit          cols;
    logic [15:0] d0, d1, d2;
    int          h, v;
  } exp_t;
  exp_t e1, e2;

  function automatic logic [15:0] pix(input int h, input int v);
    logic [15:0] p;
    p = {v[6:0], h[7:0], 1'b1};
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk_in) begin
    int h, v;
    bit acc;
    started = 1'b1;
    if (!rst_in) begin
      e1 = '{default: 0};
      e1.zero = 1'b1;
      e2 = e1;
      gen++;
    end else begin
      e2  = e1;
      h   = int'(bus.hcount_in);
      v   = int'(bus.vcount_in);
      acc = (bus.data_valid_in === 1'b1) && (h < HRES) && (v < VRES);
      e1  = '{default: 0};
      e1.vld = acc;
      if (acc) begin
        if (h == 0 && v == 0) gen++;
        e1.d0 = bus.data_in;
        e1.h  = h;
        e1.v  = v;
        if (v >= 2 && kgen[v-1][h] == gen && kgen[v-2][h] == gen) begin
          e1.cols = 1'b1;
          e1.d1   = img[v-1][h];
          e1.d2   = img[v-2][h];
        end
        img[v][h]  = bus.data_in;
        kgen[v][h] = gen;
      end
    end
  end

  always @(negedge clk_in) begin
    if (started) begin
      chk("valid", 32'(bus.data_valid_out), 32'(e2.vld));
      if (e2.zero) begin
        chk("rst_d0", 32'(bus.data_out[0]), 32'd0);
        chk("rst_d1", 32'(bus.data_out[1]), 32'd0);
        chk("rst_d2", 32'(bus.data_out[2]), 32'd0);
        chk("rst_h",  32'(bus.hcount_out),  32'd0);
        chk("rst_v",  32'(bus.vcount_out),  32'd0);
      end else if (e2.vld) begin
        chk("d0",   32'(bus.data_out[0]), 32'(e2.d0));
        chk("hcnt", 32'(bus.hcount_out),  32'(e2.h));
        chk("vcnt", 32'(bus.vcount_out),  32'(e2.v));
        if (e2.cols) begin
          chk("d1", 32'(bus.data_out[1]), 32'(e2.d1));
          chk("d2", 32'(bus.data_out[2]), 32'(e2.d2));
        end
      end
      if (frame_id == 0 && bus.data_valid_out === 1'b1 &&
          bus.hcount_out == 8'd5 && bus.vcount_out == 9'd2) begin
        seen_a = 1'b1;
        chk("pin_5_2_d0", 32'(bus.data_out[0]), 32'h040B);
        chk("pin_5_2_d1", 32'(bus.data_out[1]), 32'h020B);
        chk("pin_5_2_d2", 32'(bus.data_out[2]), 32'h000B);
      end
      if (frame_id == 0 && bus.data_valid_out === 1'b1 &&
          bus.hcount_out == 8'd239 && bus.vcount_out == 9'd4) begin
        seen_b = 1'b1;
        chk("pin_239_4_d0", 32'(bus.data_out[0]), 32'h09DF);
        chk("pin_239_4_d1", 32'(bus.data_out[1]), 32'h07DF);
        chk("pin_239_4_d2", 32'(bus.data_out[2]), 32'h05DF);
      end
    end
  end

  task automatic put(input int h, input int v, input logic [15:0] d, input bit val);
    @(negedge clk_in);
    bus.hcount_in     = h[7:0];
    bus.vcount_in     = v[8:0];
    bus.data_in       = d;
    bus.data_valid_in = val;
  endtask

  task automatic randin();
    bus.hcount_in     = 8'($urandom);
    bus.vcount_in     = 9'($urandom);
    bus.data_in       = 16'($urandom);
    bus.data_valid_in = 1'($urandom);
  endtask

  // mode 0 dense, 1 bubble after each pixel, 2 random data + random bubbles, 3 dense + out-of-range
  task automatic row(input int v, input int mode);
    for (int h = 0; h < HRES; h++) begin
      if (mode == 2 && $urandom_range(0, 3) == 0)
        put(int'($urandom_range(0, 255)), int'($urandom_range(0, 511)), 16'($urandom), 1'b0);
      put(h, v, (mode == 2) ? 16'($urandom) : pix(h, v), 1'b1);
      if (mode == 1) put(h, v, 16'hDEAD, 1'b0);
      if (mode == 3 && h == 100) begin
        put(240, v, 16'hBAD0, 1'b1);
        put(7, 320, 16'hBAD1, 1'b1);
      end
    end
  endtask

  initial begin
    bus.data_in = '0; bus.hcount_in = '0; bus.vcount_in = '0; bus.data_valid_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      randin();
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    bus.data_valid_in = 1'b0;

    frame_id = 0;
    row(0, 0); row(1, 0); row(2, 0);
    row(3, 1);
    row(4, 3);
    row(5, 0);
    row(148, 0); row(149, 0);
    for (int h = 0; h < 120; h++) put(h, 150, pix(h, 150), 1'b1);

    @(negedge clk_in);
    rst_in = 1'b0;
    bus.hcount_in = 8'd120; bus.vcount_in = 9'd150;
    bus.data_in = pix(120, 150); bus.data_valid_in = 1'b1;
    repeat (2) begin
      @(negedge clk_in);
      randin();
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    bus.data_valid_in = 1'b0;
    frame_id = 1;
    repeat (3) put(0, 0, 16'h0, 1'b0);

    row(0, 2); row(1, 2); row(2, 2); row(3, 2);
    repeat (4) put(0, 0, 16'h0, 1'b0);

    chk("seen_pin_5_2",   32'(seen_a), 32'd1);
    chk("seen_pin_239_4", 32'(seen_b), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_buffer.md
Name: line_buffer

Overview:
- Upstream neighbour of the 3x3 convolution stage.
- Takes the camera's RGB565 pixel stream (one pixel per valid cycle, raster order, 240x320 frame) and stores the two most recent complete rows in rotating block-RAM line stores.
- For every accepted pixel it emits a vertical 3-pixel column {row v-2, row v-1, row v} at the same hcount, plus aligned hcount/vcount/valid.
- The convolution stage then builds the 3x3 window horizontally.

Parameters:
- HRES, 240, pixels per row; must be ≤ 256 to fit the 8-bit hcount.
- VRES, 320, rows per frame; must be ≤ 512 to fit the 9-bit vcount.
- DATA_WIDTH, 16, pixel width (RGB565).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-low reset.
- data_in  input  DATA_WIDTH  incoming pixel.
- hcount_in  input  8  column of data_in, 0..HRES-1.
- vcount_in  input  9  row of data_in, 0..VRES-1.
- data_valid_in  input  1  data_in/hcount_in/vcount_in valid this cycle.
- data_out  output  [2:0][DATA_WIDTH-1:0]  [0] = pixel (h,v), [1] = (h,v-1), [2] = (h,v-2).
- hcount_out  output  8  h of data_out.
- vcount_out  output  9  v of data_out (newest row).
- data_valid_out  output  1  data_out valid.

Behaviour:
- Reset (rst_in low at a clock edge):
  - data_out=0, hcount_out=0, vcount_out=0, data_valid_out=0.
  - Write index wr_idx=0; both internal pipeline stages cleared to invalid.
  - RAM contents are not cleared.
- Accept condition: data_valid_in=1 and hcount_in<HRES and vcount_in<VRES. Anything else is a bubble and produces data_valid_out=0 two cycles later.
- Storage: three single-write/single-read line RAMs, HRES x DATA_WIDTH. On an accepted pixel:
  - data_in is written to RAM[wr_idx] at address hcount_in.
  - RAM[(wr_idx+2)%3] (row v-1) and RAM[(wr_idx+1)%3] (row v-2) are read at address hcount_in.
- Read/write collisions: no RAM is read and written in the same cycle, so no collision hazard exists.
- Rotation:
  - After accepting a pixel with hcount_in==HRES-1, wr_idx <= (wr_idx+1)%3, wrapping 2->0.
  - Frame sync: an accepted pixel at (h=0, v=0) is written to RAM0 regardless of wr_idx, then wr_idx tracks from 0. This takes priority over rotation.
- Latency: fixed 2 cycles, matching the 2-cycle registered RAM read.
  - data_in, hcount_in, vcount_in, the accept flag and the read-select indices are carried through a 2-stage register pipeline.
  - The output mux uses the pipelined indices, so a rotation occurring while a read is in flight does not corrupt it.
  - The pipeline always advances; there is no backpressure. Valid gaps in the input reappear as identical gaps at the output.
- Rows 0 and 1 of a frame: data_out[1]/[2] hold stale RAM contents. The downstream stage already discards v<2.
- Reset mid-row: the pipeline is flushed with no spurious valid after reset. The next frame's (0,0) resynchronises wr_idx.
- Throughput: one pixel per cycle sustained.

Decomposition:
- Shared package (e.g. video_pkg):
  - HRES, VRES constants.
  - pixel_t (16-bit RGB565) typedef.
  - HCOUNT_W=8 and VCOUNT_W=9.
- Sub-module line_ram:
  - Simple dual-port BRAM: one write port, one read port, 2-cycle registered read.
  - Parameterised on depth and width; instantiated 3x in line_buffer.
- Rotation/index control and the output mux stay in line_buffer.

Test Plan:
1. Reset values: hold rst_in=0 for 3 cycles with random inputs driven -> all outputs 0, data_valid_out=0 throughout and for 2 cycles after release.
2. Three-row fill:
   - Stimulus: stream a frame from (0,0) with pixel = {v[6:0], h[7:0], 1'b1}.
   - At v=2, h=5, two cycles after input: data_out[0]=pix(5,2), [1]=pix(5,1), [2]=pix(5,0), hcount_out=5, vcount_out=2, valid=1.
3. Rotation wrap:
   - Stimulus: continue the stream to v=4.
   - At (h=239, v=4): data_out = {pix(239,2), pix(239,3), pix(239,4)} in [2],[1],[0] order.
   - Confirms wr_idx wraps 2->0 without corruption.
4. Valid gaps:
   - Stimulus: on row 3, deassert data_valid_in every other cycle.
   - Outputs match scenario 2's pattern at the same hcounts.
   - data_valid_out toggles identically, delayed by exactly 2 cycles.
5. Out-of-range drop:
   - Stimulus: valid pixel with hcount_in=240 (or vcount_in=320).
   - data_valid_out=0 at +2; no RAM write (following row reads unchanged); wr_idx unchanged.
6. Mid-frame reset and resync:
   - Stimulus: assert reset at (120,150); restart the frame at (0,0).
   - No output valid until +2 cycles after the first new pixel.
   - At v=2, columns match the new frame's rows 0..2.
